// File: rtl/pipe_stage_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_stall_ctrl
// Description : Stall/valid controller for one pipeline-register boundary.
//               Merges stall sources into load/valid controls, with flush,
//               saturating perf counters and a freeze watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_stall_ctrl #(
    parameter int                   NUM_SRC     = 8,
    parameter logic [NUM_SRC-1:0]   FREEZE_MASK = 8'hF0,
    parameter int                   CNT_W       = 16,
    parameter int                   WDOG_LIMIT  = 64,
    localparam int                  SRC_W       = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src_stall,
    input  logic               valid_in,
    input  logic               flush,
    input  logic               perf_clr,
    input  logic               wdog_clr,
    output logic               load_out,
    output logic               valid_next,
    output logic               valid_q,
    output logic [SRC_W-1:0]   stall_src,
    output logic               stall_any,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic [CNT_W-1:0]   bubble_cycles,
    output logic               wdog_err
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic w_frz;
    logic w_bub;
    logic w_stall_inc;
    logic w_bub_inc;

    assign w_frz       = |(src_stall & FREEZE_MASK);
    assign w_bub       = |(src_stall & ~FREEZE_MASK);
    assign w_stall_inc = w_frz & ~flush;
    assign w_bub_inc   = w_bub & ~w_frz & ~flush;

    assign load_out   = flush | ~w_frz;
    assign valid_next = valid_in & ~flush & ~w_frz & ~w_bub;
    assign stall_any  = |src_stall;

    // Scan from the top so the lowest-numbered active source ends up winning.
    always_comb begin
        stall_src = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_stall[i]) begin
                stall_src = SRC_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (load_out) begin
            valid_q <= valid_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles  <= '0;
            bubble_cycles <= '0;
        end else if (perf_clr) begin
            stall_cycles  <= '0;
            bubble_cycles <= '0;
        end else begin
            if (w_stall_inc && (stall_cycles != c_cnt_max)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (w_bub_inc && (bubble_cycles != c_cnt_max)) begin
                bubble_cycles <= bubble_cycles + 1'b1;
            end
        end
    end

    generate
        if (WDOG_LIMIT > 0) begin : g_wdog
            localparam int              WD_W       = $clog2(WDOG_LIMIT + 1);
            localparam logic [WD_W-1:0] c_wd_limit = WD_W'(WDOG_LIMIT);
            localparam logic [WD_W-1:0] c_wd_pre   = WD_W'(WDOG_LIMIT - 1);

            logic [WD_W-1:0] r_run;
            logic            r_err;
            logic            w_set;

            assign w_set = w_stall_inc && (r_run == c_wd_pre);

            // A set in the same cycle as a clear takes precedence, including the run count.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_run <= '0;
                    r_err <= 1'b0;
                end else begin
                    if (wdog_clr && !w_set) begin
                        r_run <= '0;
                    end else if (w_stall_inc) begin
                        if (r_run != c_wd_limit) begin
                            r_run <= r_run + 1'b1;
                        end
                    end else begin
                        r_run <= '0;
                    end

                    if (w_set) begin
                        r_err <= 1'b1;
                    end else if (wdog_clr) begin
                        r_err <= 1'b0;
                    end
                end
            end

            assign wdog_err = r_err;
        end else begin : g_no_wdog
            assign wdog_err = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_stall_ctrl
// Description : Directed bench with a behavioural reference model for
//               pipe_stage_stall_ctrl (default and CNT_W=4/no-watchdog builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_stall_ctrl;

    localparam logic [7:0] c_mask  = 8'hF0;
    localparam int         c_limit = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] src_stall;
    logic       valid_in, flush, perf_clr, wdog_clr;

    logic        a_load, a_vnext, a_vq, a_any, a_err;
    logic [2:0]  a_src;
    logic [15:0] a_sc, a_bc;
    logic        b_load, b_vnext, b_vq, b_any, b_err;
    logic [2:0]  b_src;
    logic [3:0]  b_sc, b_bc;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_vq, m_sc1, m_bc1, m_sc2, m_bc2, m_run, m_err;

    pipe_stage_stall_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .src_stall(src_stall), .valid_in(valid_in),
        .flush(flush), .perf_clr(perf_clr), .wdog_clr(wdog_clr),
        .load_out(a_load), .valid_next(a_vnext), .valid_q(a_vq),
        .stall_src(a_src), .stall_any(a_any), .stall_cycles(a_sc),
        .bubble_cycles(a_bc), .wdog_err(a_err)
    );

    pipe_stage_stall_ctrl #(.CNT_W(4), .WDOG_LIMIT(0)) u_dut_small (
        .clk(clk), .rst_n(rst_n), .src_stall(src_stall), .valid_in(valid_in),
        .flush(flush), .perf_clr(perf_clr), .wdog_clr(wdog_clr),
        .load_out(b_load), .valid_next(b_vnext), .valid_q(b_vq),
        .stall_src(b_src), .stall_any(b_any), .stall_cycles(b_sc),
        .bubble_cycles(b_bc), .wdog_err(b_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit f_frz(input logic [7:0] s);
        bit r = 0;
        for (int i = 0; i < 8; i++) if (s[i] && c_mask[i]) r = 1;
        return r;
    endfunction

    function automatic bit f_bub(input logic [7:0] s);
        bit r = 0;
        for (int i = 0; i < 8; i++) if (s[i] && !c_mask[i]) r = 1;
        return r;
    endfunction

    function automatic int f_first(input logic [7:0] s);
        for (int i = 0; i < 8; i++) if (s[i]) return i;
        return 0;
    endfunction

    function automatic int f_inc(input int v, input int maxv);
        return (v < maxv) ? v + 1 : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vq = 0; m_sc1 = 0; m_bc1 = 0; m_sc2 = 0; m_bc2 = 0; m_run = 0; m_err = 0;
        end else begin
            bit frz, bub, adv, binc, set;
            frz  = f_frz(src_stall);
            bub  = f_bub(src_stall);
            adv  = frz && !flush;
            binc = bub && !frz && !flush;
            if (flush || !frz) m_vq = (valid_in && !flush && !frz && !bub) ? 1 : 0;
            if (perf_clr) begin
                m_sc1 = 0; m_bc1 = 0; m_sc2 = 0; m_bc2 = 0;
            end else begin
                if (adv)  begin m_sc1 = f_inc(m_sc1, 65535); m_sc2 = f_inc(m_sc2, 15); end
                if (binc) begin m_bc1 = f_inc(m_bc1, 65535); m_bc2 = f_inc(m_bc2, 15); end
            end
            set = adv && (m_run + 1 == c_limit);
            if (wdog_clr && !set) m_run = 0;
            else if (adv)         m_run = f_inc(m_run, c_limit);
            else                  m_run = 0;
            if (set)           m_err = 1;
            else if (wdog_clr) m_err = 0;
        end
    end

    always @(negedge clk) begin
        bit frz, bub;
        int vn, ld;
        frz = f_frz(src_stall);
        bub = f_bub(src_stall);
        ld  = (flush || !frz) ? 1 : 0;
        vn  = (valid_in && !flush && !frz && !bub) ? 1 : 0;
        chk("load_out",      32'(a_load),  32'(ld));
        chk("valid_next",    32'(a_vnext), 32'(vn));
        chk("valid_q",       32'(a_vq),    32'(m_vq));
        chk("stall_src",     32'(a_src),   32'(f_first(src_stall)));
        chk("stall_any",     32'(a_any),   32'(src_stall != 0));
        chk("stall_cycles",  32'(a_sc),    32'(m_sc1));
        chk("bubble_cycles", 32'(a_bc),    32'(m_bc1));
        chk("wdog_err",      32'(a_err),   32'(m_err));
        chk("small_valid_q", 32'(b_vq),    32'(m_vq));
        chk("small_stall",   32'(b_sc),    32'(m_sc2));
        chk("small_bubble",  32'(b_bc),    32'(m_bc2));
        chk("small_wdog",    32'(b_err),   32'd0);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct { logic [7:0] s; logic v; logic f; } vec_t;
    vec_t vecs[$] = '{
        '{8'h10, 1'b1, 1'b0}, '{8'h0F, 1'b1, 1'b0}, '{8'h06, 1'b0, 1'b0},
        '{8'h40, 1'b1, 1'b1}, '{8'h00, 1'b0, 1'b0}, '{8'h00, 1'b1, 1'b1},
        '{8'h0C, 1'b1, 1'b1}, '{8'h00, 1'b1, 1'b0}, '{8'hA0, 1'b1, 1'b0}
    };

    initial begin
        rst_n = 1'b0; src_stall = '0; valid_in = 1'b1;
        flush = 1'b0; perf_clr = 1'b0; wdog_clr = 1'b0;
        cyc(2);
        chk("rst_valid_q", 32'(a_vq), 32'd0);
        chk("rst_stall",   32'(a_sc), 32'd0);
        chk("rst_wdog",    32'(a_err), 32'd0);
        rst_n = 1'b1;

        // Idle pass-through
        cyc(1);
        chk("idle_vq_1st", 32'(a_vq), 32'd1);
        cyc(2);
        chk("idle_load", 32'(a_load), 32'd1);
        chk("idle_cnts", 32'(a_sc) + 32'(a_bc), 32'd0);

        // Bubble source
        src_stall = 8'h01;
        cyc(2);
        chk("bub_vnext", 32'(a_vnext), 32'd0);
        chk("bub_vq",    32'(a_vq), 32'd0);
        chk("bub_count", 32'(a_bc), 32'd2);
        chk("bub_src",   32'(a_src), 32'd0);

        // Freeze overrides bubble and keeps valid_q
        src_stall = 8'h00;
        cyc(1);
        src_stall = 8'h21;
        #1;
        chk("frz_load", 32'(a_load), 32'd0);
        chk("frz_src",  32'(a_src), 32'd0);
        cyc(1);
        chk("frz_vq",     32'(a_vq), 32'd1);
        chk("frz_stall",  32'(a_sc), 32'd1);
        chk("frz_bubble", 32'(a_bc), 32'd2);

        // Flush over freeze
        flush = 1'b1;
        #1;
        chk("flush_load",  32'(a_load), 32'd1);
        chk("flush_vnext", 32'(a_vnext), 32'd0);
        cyc(1);
        chk("flush_vq",    32'(a_vq), 32'd0);
        chk("flush_stall", 32'(a_sc), 32'd1);
        flush = 1'b0;

        // Watchdog
        src_stall = 8'h80;
        cyc(63);
        chk("wdog_63", 32'(a_err), 32'd0);
        cyc(1);
        chk("wdog_64", 32'(a_err), 32'd1);
        src_stall = 8'h00; wdog_clr = 1'b1;
        cyc(1);
        chk("wdog_clr", 32'(a_err), 32'd0);
        wdog_clr = 1'b0; src_stall = 8'h80;
        cyc(63);
        wdog_clr = 1'b1;
        cyc(1);
        chk("wdog_set_wins", 32'(a_err), 32'd1);
        src_stall = 8'h00;
        cyc(1);
        chk("wdog_clr2", 32'(a_err), 32'd0);
        wdog_clr = 1'b0;

        foreach (vecs[k]) begin
            src_stall = vecs[k].s; valid_in = vecs[k].v; flush = vecs[k].f;
            cyc(1);
        end
        valid_in = 1'b1; flush = 1'b0;

        // Saturation on the narrow counter build
        src_stall = 8'h80; perf_clr = 1'b1;
        cyc(1);
        perf_clr = 1'b0;
        chk("pclr_a", 32'(a_sc), 32'd0);
        chk("pclr_b", 32'(b_sc), 32'd0);
        cyc(20);
        chk("sat_b", 32'(b_sc), 32'd15);
        chk("sat_a", 32'(a_sc), 32'd20);
        perf_clr = 1'b1;
        cyc(1);
        perf_clr = 1'b0;
        chk("pclr_frz_b", 32'(b_sc), 32'd0);
        chk("pclr_frz_a", 32'(a_sc), 32'd0);

        // Reset mid-freeze
        cyc(5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(a_sc), 32'd0);
        chk("mid_rst_vq",    32'(a_vq), 32'd0);
        cyc(1);
        rst_n = 1'b1; src_stall = 8'h00;
        cyc(2);
        chk("post_rst_vq", 32'(a_vq), 32'd1);

        cyc(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
